// File: rtl/mac_output_neuron.sv
// mac_output_neuron: time-multiplexed output neuron.
// Takes a captured activation/weight vector and accumulates one lane product per
// cycle into a saturating accumulator. It then computes the squared error against
// the captured target and presents all results with a single-cycle done pulse.
module mac_output_neuron #(
  parameter int N_IN  = 8,
  parameter int X_W   = 10,
  parameter int W_W   = 8,
  parameter int ACC_W = 23,
  parameter int TGT_W = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    clr_i,
  input  logic [N_IN*X_W-1:0]     x_i,
  input  logic [N_IN*W_W-1:0]     w_i,
  input  logic [TGT_W-1:0]        target_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ACC_W-1:0]        final_o,
  output logic [2*ACC_W-1:0]      loss_o,
  output logic                    zero_o,
  output logic                    sat_o,
  output logic [N_IN*W_W-1:0]     weights_o
);

  localparam int PROD_W = X_W + W_W;
  localparam int SUM_W  = ACC_W + 1;
  localparam int LOSS_W = 2 * ACC_W;
  localparam int K_W    = $clog2(N_IN);
  localparam logic [K_W-1:0]   LAST_K  = K_W'(N_IN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_LOSS
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [N_IN*X_W-1:0]    r_x;
  logic [N_IN*W_W-1:0]    r_w;
  logic [TGT_W-1:0]       r_tgt;
  logic [ACC_W-1:0]       r_acc;
  logic [K_W-1:0]         r_k;
  logic                   r_sat;

  logic [ACC_W-1:0]       r_final;
  logic [LOSS_W-1:0]      r_loss;
  logic                   r_zero;
  logic                   r_sat_out;
  logic [N_IN*W_W-1:0]    r_weights;
  logic                   r_done;

  logic [X_W-1:0]         w_x_lane;
  logic [W_W-1:0]         w_w_lane;
  logic [PROD_W-1:0]      w_prod;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_ovf;
  logic [ACC_W-1:0]       w_acc_next;
  logic [ACC_W-1:0]       w_tgt_ext;
  logic [ACC_W-1:0]       w_diff;
  logic [LOSS_W-1:0]      w_loss;
  logic                   w_zero;

  // Select the lane addressed by the lane counter.
  always_comb begin
    w_x_lane = '0;
    w_w_lane = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (r_k == K_W'(k)) begin
        w_x_lane = r_x[k*X_W +: X_W];
        w_w_lane = r_w[k*W_W +: W_W];
      end
    end
  end

  // Lane product, saturating accumulate and absolute-difference squared loss.
  always_comb begin
    w_prod     = {{W_W{1'b0}}, w_x_lane} * {{X_W{1'b0}}, w_w_lane};
    w_sum      = {1'b0, r_acc} + SUM_W'(w_prod);
    w_ovf      = w_sum[ACC_W];
    w_acc_next = w_ovf ? ACC_MAX : w_sum[ACC_W-1:0];
    w_tgt_ext  = ACC_W'(r_tgt);
    w_diff     = (r_acc >= w_tgt_ext) ? (r_acc - w_tgt_ext) : (w_tgt_ext - r_acc);
    w_loss     = LOSS_W'(w_diff) * LOSS_W'(w_diff);
    w_zero     = (r_acc == '0) && (r_tgt == '0);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: IDLE -> MAC for N_IN lanes -> one LOSS cycle -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_MAC;
      S_MAC:   if (r_k == LAST_K) w_next = S_LOSS;
      S_LOSS:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_o = (r_state != S_IDLE);
  end

  // Operand capture, lane counter, accumulator and sticky saturation flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_x   <= '0;
      r_w   <= '0;
      r_tgt <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_sat <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_x   <= x_i;
            r_w   <= w_i;
            r_tgt <= target_i;
            r_acc <= '0;
            r_k   <= '0;
            r_sat <= 1'b0;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + K_W'(1);
          if (w_ovf) r_sat <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded together in LOSS, cleared by clr_i only while idle.
  // clr_i and start_i in the same idle cycle both act, since they touch disjoint registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_final   <= '0;
      r_loss    <= '0;
      r_zero    <= 1'b0;
      r_sat_out <= 1'b0;
      r_weights <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clr_i) begin
            r_final   <= '0;
            r_loss    <= '0;
            r_zero    <= 1'b0;
            r_sat_out <= 1'b0;
          end
        end
        S_LOSS: begin
          r_final   <= r_acc;
          r_loss    <= w_loss;
          r_zero    <= w_zero;
          r_sat_out <= r_sat;
          r_weights <= r_w;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done_o    = r_done;
  assign final_o   = r_final;
  assign loss_o    = r_loss;
  assign zero_o    = r_zero;
  assign sat_o     = r_sat_out;
  assign weights_o = r_weights;

endmodule

// File: tb/tb_mac_output_neuron.sv
// Testbench for mac_output_neuron: table-driven vectors with a result scoreboard,
// plus hand-written sequences for busy/back-to-back/clear/reset/saturation cases.
module tb_mac_output_neuron;

  localparam int NI  = 8;
  localparam int XW  = 10;
  localparam int WW  = 8;
  localparam int AW  = 23;
  localparam int TW  = 4;
  localparam int AW2 = 20;
  localparam int XV  = NI * XW;
  localparam int WV  = NI * WW;
  localparam int LAT = NI + 2;

  typedef struct {
    logic [XV-1:0]   x;
    logic [WV-1:0]   w;
    logic [TW-1:0]   t;
    logic [AW-1:0]   f;
    logic [2*AW-1:0] l;
    logic            z;
    logic            s;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i, start_i, clr_i;
  logic [XV-1:0]   x_i;
  logic [WV-1:0]   w_i;
  logic [TW-1:0]   target_i;
  logic            busy_o, done_o, zero_o, sat_o;
  logic [AW-1:0]   final_o;
  logic [2*AW-1:0] loss_o;
  logic [WV-1:0]   weights_o;

  logic s_start, s_clr;
  logic [XV-1:0]    s_x;
  logic [WV-1:0]    s_w;
  logic [TW-1:0]    s_t;
  logic             s_busy, s_done, s_zero, s_sat;
  logic [AW2-1:0]   s_final;
  logic [2*AW2-1:0] s_loss;
  logic [WV-1:0]    s_weights;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  vec_t sb[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  mac_output_neuron #(.N_IN(NI), .X_W(XW), .W_W(WW), .ACC_W(AW), .TGT_W(TW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clr_i(clr_i),
    .x_i(x_i), .w_i(w_i), .target_i(target_i),
    .busy_o(busy_o), .done_o(done_o), .final_o(final_o), .loss_o(loss_o),
    .zero_o(zero_o), .sat_o(sat_o), .weights_o(weights_o)
  );

  mac_output_neuron #(.N_IN(NI), .X_W(XW), .W_W(WW), .ACC_W(AW2), .TGT_W(TW)) dut_s (
    .clk_i(clk), .rst_i(rst_i), .start_i(s_start), .clr_i(s_clr),
    .x_i(s_x), .w_i(s_w), .target_i(s_t),
    .busy_o(s_busy), .done_o(s_done), .final_o(s_final), .loss_o(s_loss),
    .zero_o(s_zero), .sat_o(s_sat), .weights_o(s_weights)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [XV-1:0] rep_x(input logic [XW-1:0] v);
    logic [XV-1:0] r;
    for (int i = 0; i < NI; i++) r[i*XW +: XW] = v;
    return r;
  endfunction

  function automatic logic [WV-1:0] rep_w(input logic [WW-1:0] v);
    logic [WV-1:0] r;
    for (int i = 0; i < NI; i++) r[i*WW +: WW] = v;
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  initial begin
    logic prev_done;
    vec_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        done_cnt++;
        chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("final", final_o, e.f);
          chk("loss", loss_o, e.l);
          chk("zero", zero_o, e.z);
          chk("sat", sat_o, e.s);
          chk("weights", weights_o, e.w);
        end
      end
      prev_done = done_o;
    end
  end

  // Called just after a negedge: start is sampled at the next posedge, then inputs are scrambled.
  task automatic drive_start(input vec_t v);
    x_i      = v.x;
    w_i      = v.w;
    target_i = v.t;
    start_i  = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    x_i      = XV'({$urandom, $urandom, $urandom});
    w_i      = {$urandom, $urandom};
    target_i = TW'($urandom);
  endtask

  // Counts cycles after the start edge (n0 already elapsed) until done_o; bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_start", busy_o, 1);
    end while (done_o !== 1'b1 && n < 40);
    chk("done_seen", done_o, 1);
    chk("latency", n, LAT);
    chk("busy_in_done_cycle", busy_o, 0);
  endtask

  task automatic s_op(input logic [XV-1:0] x, input logic [WV-1:0] w, input logic [TW-1:0] t);
    int n;
    s_x = x; s_w = w; s_t = t; s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    n = 0;
    while (s_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sat_dut_done", s_done, 1);
    chk("sat_dut_latency", n, LAT);
  endtask

  initial begin
    int n, d0;
    logic [XV-1:0] rx;
    logic [WV-1:0] rw;

    for (int i = 0; i < NI; i++) begin
      rx[i*XW +: XW] = XW'(i);
      rw[i*WW +: WW] = WW'(i + 1);
    end
    tbl[0] = '{rep_x(10'd3),    rep_w(8'd2),   4'd5,  23'd48,      46'd1849,          1'b0, 1'b0};
    tbl[1] = '{rep_x(10'd0),    rep_w(8'd2),   4'd9,  23'd0,       46'd81,            1'b0, 1'b0};
    tbl[2] = '{rep_x(10'd0),    rep_w(8'd0),   4'd0,  23'd0,       46'd0,             1'b1, 1'b0};
    tbl[3] = '{rep_x(10'd1023), rep_w(8'd255), 4'd15, 23'd2086920, 46'd4355172479025, 1'b0, 1'b0};
    tbl[4] = '{rep_x(10'd1),    rep_w(8'd1),   4'd15, 23'd8,       46'd49,            1'b0, 1'b0};
    tbl[5] = '{rep_x(10'd100),  rep_w(8'd128), 4'd0,  23'd102400,  46'd10485760000,   1'b0, 1'b0};
    tbl[6] = '{rx,              rw,            4'd8,  23'd168,     46'd25600,         1'b0, 1'b0};

    rst_i = 1'b0; start_i = 1'b0; clr_i = 1'b0;
    x_i = '0; w_i = '0; target_i = '0;
    s_start = 1'b0; s_clr = 1'b0; s_x = '0; s_w = '0; s_t = '0;
    repeat (3) @(negedge clk);
    chk("rst_final", final_o, 0);
    chk("rst_loss", loss_o, 0);
    chk("rst_zero", zero_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_weights", weights_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      drive_start(tbl[i]);
      wait_done(0, n);
      @(negedge clk);
    end

    // clr_i during an operation is ignored: previous results (168) hold.
    drive_start(tbl[0]);
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_busy_ignored", final_o, 168);
    wait_done(2, n);
    @(negedge clk);

    // clr_i and start_i together in IDLE: outputs clear and the operation runs.
    clr_i = 1'b1;
    drive_start(tbl[4]);
    clr_i = 1'b0;
    chk("clr_with_start_final", final_o, 0);
    chk("clr_with_start_loss", loss_o, 0);
    wait_done(0, n);
    @(negedge clk);

    // Plain clear in IDLE; weights_o is not part of the clear.
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_final", final_o, 0);
    chk("clr_loss", loss_o, 0);
    chk("clr_weights_held", weights_o, rep_w(8'd1));

    // Second start while busy is ignored.
    drive_start(tbl[5]);
    d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    x_i = rep_x(10'd7); w_i = rep_w(8'd3); target_i = 4'd1; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(2, n);
    repeat (15) @(negedge clk);
    chk("busy_start_one_done", done_cnt - d0, 1);

    // Back-to-back: start in the done cycle.
    drive_start(tbl[1]);
    wait_done(0, n);
    drive_start(tbl[6]);
    wait_done(0, n);
    @(negedge clk);

    // Reset during MAC lane 4 aborts with outputs cleared and no done.
    drive_start(tbl[3]);
    repeat (5) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("abort_final", final_o, 0);
    chk("abort_loss", loss_o, 0);
    chk("abort_weights", weights_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    void'(sb.pop_back());
    d0 = done_cnt;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    drive_start(tbl[0]);
    wait_done(0, n);
    @(negedge clk);

    // Saturation with a 20-bit accumulator, then a clean operation clears the flag.
    s_op(rep_x(10'd1023), rep_w(8'd255), 4'd0);
    chk("sat_final", s_final, 1048575);
    chk("sat_flag", s_sat, 1);
    chk("sat_loss", s_loss, 64'd1099509530625);
    @(negedge clk);
    s_op(rep_x(10'd1), rep_w(8'd1), 4'd0);
    chk("unsat_final", s_final, 8);
    chk("unsat_flag", s_sat, 0);
    chk("unsat_loss", s_loss, 64);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
